// File: rtl/fpu_mantissa_normalizer.sv
// ---------------------------------------------------------------------------
// fpu_mantissa_normalizer
//
// Multi-cycle left-normalizer for 64-bit extended-precision mantissas. It sits
// after the adder/multiplier datapath and before rounding. Whole leading zero
// bytes are removed in one cycle through a mux-based byte shifter. Any
// remaining leading zero bits (at most 7) are removed one bit per cycle. The
// biased exponent is decremented to match every shift. Shifting stops at the
// denormal boundary, where the exponent would otherwise drop below 1.
//
// Ports
//   clk             in   1          clock, rising edge
//   reset_n         in   1          asynchronous active-low reset
//   in_valid        in   1          input operand valid
//   in_ready        out  1          block can accept (state == IDLE)
//   in_mantissa     in   64         unnormalized mantissa, bit 63 = integer bit
//   in_exponent     in   EXP_WIDTH  biased exponent
//   in_sign         in   1          sign, passed through
//   out_valid       out  1          result valid, held until out_ready
//   out_ready       in   1          downstream accepts result
//   out_mantissa    out  64         normalized (or denormal) mantissa
//   out_exponent    out  EXP_WIDTH  adjusted biased exponent
//   out_sign        out  1          registered sign
//   out_zero        out  1          input mantissa was zero
//   out_denormal    out  1          stopped at exponent 1 with bit 63 still 0
//   out_shift_count out  7          total left shifts applied (0..63)
// ---------------------------------------------------------------------------

// Left shift by 0..7 whole bytes, built as three binary mux stages.
module multiplexer_based_byte_shifter_left (
    input  logic [63:0] data_i,
    input  logic [2:0]  shift_bytes_i,
    output logic [63:0] data_o
);
    logic [63:0] stage1;
    logic [63:0] stage2;

    always_comb begin
        stage1 = shift_bytes_i[0] ? {data_i[55:0], 8'h00}  : data_i;
        stage2 = shift_bytes_i[1] ? {stage1[47:0], 16'h0}  : stage1;
        data_o = shift_bytes_i[2] ? {stage2[31:0], 32'h0}  : stage2;
    end
endmodule

// State | Meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for an operand; in_ready high
// BYTE  | zero check, then one multi-byte shift limited by the budget
// BIT   | single-bit shifts until bit 63 is set or the budget runs out
// DONE  | result latched; out_valid rises one cycle later, held until out_ready
module fpu_mantissa_normalizer #(
    parameter int EXP_WIDTH = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_mantissa,
    input  logic [EXP_WIDTH-1:0] in_exponent,
    input  logic                 in_sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_mantissa,
    output logic [EXP_WIDTH-1:0] out_exponent,
    output logic                 out_sign,
    output logic                 out_zero,
    output logic                 out_denormal,
    output logic [6:0]           out_shift_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BYTE = 2'd1,
        S_BIT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Working registers
    logic [63:0]          mant_q,   mant_d;
    logic [EXP_WIDTH-1:0] exp_q,    exp_d;
    // Remaining number of shifts allowed before the exponent would reach 0
    logic [EXP_WIDTH-1:0] budget_q, budget_d;
    logic [6:0]           count_q,  count_d;
    logic                 sign_q,   sign_d;

    // Output registers
    logic                 out_valid_q,    out_valid_d;
    logic [63:0]          out_mant_q,     out_mant_d;
    logic [EXP_WIDTH-1:0] out_exp_q,      out_exp_d;
    logic                 out_sign_q,     out_sign_d;
    logic                 out_zero_q,     out_zero_d;
    logic                 out_den_q,      out_den_d;
    logic [6:0]           out_count_q,    out_count_d;

    // Byte-step datapath
    logic [3:0]           lzb;
    logic                 lzb_found;
    logic [EXP_WIDTH-1:0] budget_bytes;
    logic [2:0]           k_bytes;
    logic [5:0]           k_bits;
    logic [EXP_WIDTH-1:0] k_bits_e;
    logic [6:0]           k_bits_c;
    logic [63:0]          mant_byte_shifted;

    // Leading zero bytes, scanned from the top byte. The all-zero case
    // is handled separately, so the result used is always 0..7.
    always_comb begin
        lzb       = 4'd0;
        lzb_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!lzb_found) begin
                if (mant_q[i*8 +: 8] == 8'h00) begin
                    lzb = lzb + 4'd1;
                end else begin
                    lzb_found = 1'b1;
                end
            end
        end
    end

    // The byte step never uses more shifts than the budget allows; any
    // leftover budget below one byte is spent in the bit loop.
    always_comb begin
        budget_bytes = budget_q >> 3;
        if (budget_bytes < EXP_WIDTH'(lzb)) begin
            k_bytes = budget_bytes[2:0];
        end else begin
            k_bytes = lzb[2:0];
        end
        k_bits   = {k_bytes, 3'b000};
        k_bits_e = EXP_WIDTH'(k_bits);
        k_bits_c = 7'(k_bits);
    end

    multiplexer_based_byte_shifter_left u_byte_shifter (
        .data_i        (mant_q),
        .shift_bytes_i (k_bytes),
        .data_o        (mant_byte_shifted)
    );

    always_comb begin
        state_d     = state_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        budget_d    = budget_q;
        count_d     = count_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;
        out_mant_d  = out_mant_q;
        out_exp_d   = out_exp_q;
        out_sign_d  = out_sign_q;
        out_zero_d  = out_zero_q;
        out_den_d   = out_den_q;
        out_count_d = out_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mant_d   = in_mantissa;
                    exp_d    = in_exponent;
                    sign_d   = in_sign;
                    count_d  = 7'd0;
                    budget_d = (in_exponent == '0) ? '0
                                                   : in_exponent - EXP_WIDTH'(1);
                    state_d  = S_BYTE;
                end
            end

            S_BYTE: begin
                if (mant_q == 64'h0) begin
                    out_mant_d  = 64'h0;
                    out_exp_d   = '0;
                    out_sign_d  = sign_q;
                    out_zero_d  = 1'b1;
                    out_den_d   = 1'b0;
                    out_count_d = 7'd0;
                    state_d     = S_DONE;
                end else begin
                    mant_d   = mant_byte_shifted;
                    exp_d    = exp_q - k_bits_e;
                    budget_d = budget_q - k_bits_e;
                    count_d  = count_q + k_bits_c;
                    state_d  = S_BIT;
                end
            end

            S_BIT: begin
                if (!mant_q[63] && (budget_q != '0)) begin
                    mant_d   = {mant_q[62:0], 1'b0};
                    exp_d    = exp_q - EXP_WIDTH'(1);
                    budget_d = budget_q - EXP_WIDTH'(1);
                    count_d  = count_q + 7'd1;
                end else begin
                    // Still unnormalized here means the budget ran out:
                    // the result is denormal and takes exponent 0.
                    out_mant_d  = mant_q;
                    out_exp_d   = mant_q[63] ? exp_q : '0;
                    out_sign_d  = sign_q;
                    out_zero_d  = 1'b0;
                    out_den_d   = ~mant_q[63];
                    out_count_d = count_q;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mant_q      <= 64'h0;
            exp_q       <= '0;
            budget_q    <= '0;
            count_q     <= 7'd0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_mant_q  <= 64'h0;
            out_exp_q   <= '0;
            out_sign_q  <= 1'b0;
            out_zero_q  <= 1'b0;
            out_den_q   <= 1'b0;
            out_count_q <= 7'd0;
        end else begin
            state_q     <= state_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            budget_q    <= budget_d;
            count_q     <= count_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            out_mant_q  <= out_mant_d;
            out_exp_q   <= out_exp_d;
            out_sign_q  <= out_sign_d;
            out_zero_q  <= out_zero_d;
            out_den_q   <= out_den_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready        = (state_q == S_IDLE);
    assign out_valid       = out_valid_q;
    assign out_mantissa    = out_mant_q;
    assign out_exponent    = out_exp_q;
    assign out_sign        = out_sign_q;
    assign out_zero        = out_zero_q;
    assign out_denormal    = out_den_q;
    assign out_shift_count = out_count_q;

endmodule

// File: tb/tb_fpu_mantissa_normalizer.sv
// Bench for fpu_mantissa_normalizer: fixed vectors, backpressure, mid-operation
// reset and randomized operands checked against a plain-arithmetic model.
// Latency is the number of rising edges after the accept edge up to and
// including the edge that raises out_valid.
module tb_fpu_mantissa_normalizer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_mantissa;
    logic [14:0] in_exponent;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_mantissa;
    logic [14:0] out_exponent;
    logic        out_sign;
    logic        out_zero;
    logic        out_denormal;
    logic [6:0]  out_shift_count;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_mantissa_normalizer #(.EXP_WIDTH(15)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_mantissa     (in_mantissa),
        .in_exponent     (in_exponent),
        .in_sign         (in_sign),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_mantissa    (out_mantissa),
        .out_exponent    (out_exponent),
        .out_sign        (out_sign),
        .out_zero        (out_zero),
        .out_denormal    (out_denormal),
        .out_shift_count (out_shift_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] m;
        logic [14:0] e;
        logic        s;
        logic [63:0] xm;
        logic [14:0] xe;
        logic        xz;
        logic        xd;
        int          xc;
        int          xl;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: total shifts = min(leading zeros, exponent-1); the byte step
    // takes whole bytes up to the same limit, the rest are single-bit cycles.
    function automatic vec_t model(input logic [63:0] m, input logic [14:0] e, input logic s);
        vec_t r;
        int lz, budget, sh, byte_sh;
        r.m = m; r.e = e; r.s = s;
        if (m == 64'h0) begin
            r.xm = 64'h0; r.xe = 15'h0; r.xz = 1'b1; r.xd = 1'b0; r.xc = 0; r.xl = 2;
            return r;
        end
        lz = 0;
        while (lz < 64 && m[63-lz] == 1'b0) lz++;
        budget  = (e == 15'h0) ? 0 : int'(e) - 1;
        sh      = (lz < budget) ? lz : budget;
        byte_sh = 8 * (((lz / 8) < (budget / 8)) ? (lz / 8) : (budget / 8));
        r.xm = m << sh;
        r.xz = 1'b0;
        r.xd = ~r.xm[63];
        r.xe = r.xd ? 15'h0 : 15'(int'(e) - sh);
        r.xc = sh;
        r.xl = 2 + (sh - byte_sh) + 1;
        return r;
    endfunction

    task automatic check_result(input string tag, input vec_t v, input int lat);
        chk({tag, " latency"},  64'(lat),          64'(v.xl));
        chk({tag, " mantissa"}, out_mantissa,      v.xm);
        chk({tag, " exponent"}, 64'(out_exponent), 64'(v.xe));
        chk({tag, " sign"},     64'(out_sign),     64'(v.s));
        chk({tag, " zero"},     64'(out_zero),     64'(v.xz));
        chk({tag, " denormal"}, 64'(out_denormal), 64'(v.xd));
        chk({tag, " count"},    64'(out_shift_count), 64'(v.xc));
    endtask

    // Called 1 time unit after a rising edge with the DUT idle.
    task automatic accept_and_wait(input vec_t v, output int lat);
        in_mantissa = v.m;
        in_exponent = v.e;
        in_sign     = v.s;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        accept_and_wait(v, lat);
        check_result(tag, v, lat);
        @(posedge clk); #1;
        chk({tag, " handshake valid drop"}, 64'(out_valid), 64'(0));
        chk({tag, " ready after"},          64'(in_ready),  64'(1));
    endtask

    vec_t vecs[10];
    vec_t v, v2;
    int   lat;
    logic [63:0] held_m;
    logic [14:0] held_e;

    initial begin
        vecs[0] = '{64'h0000_0000_0000_0001, 15'h3FFF, 1'b0, 64'h8000_0000_0000_0000, 15'h3FC0, 1'b0, 1'b0, 63, 10};
        vecs[1] = '{64'h8000_0000_0000_0000, 15'h4000, 1'b0, 64'h8000_0000_0000_0000, 15'h4000, 1'b0, 1'b0, 0, 3};
        vecs[2] = '{64'h0,                   15'h1234, 1'b1, 64'h0,                   15'h0000, 1'b1, 1'b0, 0, 2};
        vecs[3] = '{64'h00FF_0000_0000_0000, 15'd5,    1'b0, 64'h0FF0_0000_0000_0000, 15'h0000, 1'b0, 1'b1, 4, 7};
        vecs[4] = '{64'h0000_0000_0000_0001, 15'd20,   1'b1, 64'h0000_0000_0008_0000, 15'h0000, 1'b0, 1'b1, 19, 6};
        vecs[5] = '{64'h4000_0000_0000_0000, 15'd1,    1'b0, 64'h4000_0000_0000_0000, 15'h0000, 1'b0, 1'b1, 0, 3};
        vecs[6] = '{64'h8000_0000_0000_0000, 15'd0,    1'b1, 64'h8000_0000_0000_0000, 15'h0000, 1'b0, 1'b0, 0, 3};
        vecs[7] = '{64'h0000_0000_0000_0100, 15'h0100, 1'b0, 64'h8000_0000_0000_0000, 15'h00C9, 1'b0, 1'b0, 55, 10};
        vecs[8] = '{64'h0000_0010_0000_0000, 15'h3FFF, 1'b1, 64'h8000_0000_0000_0000, 15'h3FE4, 1'b0, 1'b0, 27, 6};
        vecs[9] = '{64'h0123_4567_89AB_CDEF, 15'd0,    1'b0, 64'h0123_4567_89AB_CDEF, 15'h0000, 1'b0, 1'b1, 0, 3};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_mantissa = '0; in_exponent = '0; in_sign = 1'b0;
        #23;
        chk("reset in_ready",  64'(in_ready),  64'(1));
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset mantissa",  out_mantissa,   64'h0);
        chk("reset count",     64'(out_shift_count), 64'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: result must hold and a second operand must wait.
        out_ready = 1'b0;
        accept_and_wait(vecs[0], lat);
        check_result("bp first", vecs[0], lat);
        held_m = out_mantissa;
        held_e = out_exponent;
        in_mantissa = vecs[1].m; in_exponent = vecs[1].e; in_sign = vecs[1].s;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp valid held",    64'(out_valid),    64'(1));
            chk("bp in_ready low",  64'(in_ready),     64'(0));
            chk("bp mantissa held", out_mantissa,      held_m);
            chk("bp exponent held", 64'(out_exponent), 64'(held_e));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp handshake valid", 64'(out_valid), 64'(0));
        chk("bp idle ready",      64'(in_ready),  64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp second taken", 64'(in_ready), 64'(0));
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_result("bp second", vecs[1], lat);
        @(posedge clk); #1;

        // Reset during the bit loop of vector 0.
        in_mantissa = vecs[0].m; in_exponent = vecs[0].e; in_sign = vecs[0].s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("abort out_valid", 64'(out_valid), 64'(0));
        chk("abort in_ready",  64'(in_ready),  64'(1));
        chk("abort mantissa",  out_mantissa,   64'h0);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_vec("after abort", vecs[1]);

        // Randomized operands against the model.
        for (int n = 0; n < 300; n++) begin
            logic [63:0] m;
            logic [14:0] e;
            m = {$urandom, $urandom};
            m = m >> $urandom_range(0, 63);
            if ($urandom_range(0, 19) == 0) m = 64'h0;
            if ($urandom_range(0, 1) == 0) e = 15'($urandom_range(0, 80));
            else                           e = 15'($urandom);
            v2 = model(m, e, 1'($urandom));
            run_vec($sformatf("rand%0d", n), v2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
